// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: program ram address/data, jump redirect and decoder valid/ready.
// The master modport is the fetch unit side; slave is the ram/decoder environment.
interface instr_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_addr;
  logic              valid;
  logic              ready;

  modport master (
    output address, instr, instr_addr, valid,
    input  data, jump, jump_addr, ready
  );

  modport slave (
    input  address, instr, instr_addr, valid,
    output data, jump, jump_addr, ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: drives the synchronous program ram from the PC, captures returned
// words into a small prefetch FIFO and hands them to decode; a jump flushes everything.
module instr_fetch #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int LAST_ADDR = 127
) (
  input  logic           clk,
  input  logic           rst,
  instr_fetch_if.master  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(LAST_ADDR);
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [DATA_W-1:0] word_q [DEPTH];
  logic [DATA_W-1:0] word_d [DEPTH];
  logic [ADDR_W-1:0] waddr_q [DEPTH];
  logic [ADDR_W-1:0] waddr_d [DEPTH];

  logic issue, push, pop;

  // Credit counts the in-flight request so a returning word always has a free slot.
  always_comb begin
    issue = !bus.jump &&
            (({1'b0, count_q} + {{CNT_W{1'b0}}, req_q}) < DEPTH_C);
    push  = req_q && !bus.jump;
    pop   = (count_q != '0) && bus.ready && !bus.jump;
  end

  always_comb begin
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    word_d  = word_q;
    waddr_d = waddr_q;

    if (bus.jump) begin
      req_d   = 1'b0;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      pc_d    = (bus.jump_addr <= LAST) ? bus.jump_addr : '0;
    end else begin
      req_d = issue;
      if (issue) begin
        addr_d = pc_q;
        pc_d   = (pc_q == LAST) ? '0 : pc_q + ADDR_W'(1);
      end
      if (push) begin
        word_d[tail_q]  = bus.data;
        waddr_d[tail_q] = addr_q;
        tail_d          = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i]  <= '0;
        waddr_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      word_q  <= word_d;
      waddr_q <= waddr_d;
    end
  end

  assign bus.address    = pc_q;
  assign bus.instr      = word_q[head_q];
  assign bus.instr_addr = waddr_q[head_q];
  assign bus.valid      = (count_q != '0);
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: synchronous ram model plus an expected-address scoreboard
// (sequential addresses from the last redirect target, wrapping after 127).
module tb_instr_fetch;
  localparam logic [7:0] LAST = 8'd127;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_addr;
  logic [7:0] exp_a;
  logic [7:0] got_i, got_a;
  logic       got_v, acc;

  instr_fetch_if #(.ADDR_W(8), .DATA_W(8)) ifc ();

  instr_fetch #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .LAST_ADDR(127)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ifc.data <= mem[ifc.address];

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (dut.count_q > 3'd4) begin
        errors++;
        $display("FAIL count_bound: count %0d exceeds 4", dut.count_q);
      end
    end
  end

  function automatic logic [7:0] nxt(input logic [7:0] a);
    return (a == LAST) ? 8'd0 : a + 8'd1;
  endfunction

  // Drives one cycle (called just after a posedge), samples at the negedge and
  // advances the reference model; returns just after the following posedge.
  task automatic tick(input logic rdy, input logic jmp, input logic [7:0] ja);
    ifc.ready     = rdy;
    ifc.jump      = jmp;
    ifc.jump_addr = ja;
    @(negedge clk);
    got_v = ifc.valid;
    got_i = ifc.instr;
    got_a = ifc.instr_addr;
    acc   = got_v && rdy && !jmp;
    exp_a = exp_addr;
    if (jmp) exp_addr = (ja <= LAST) ? ja : 8'd0;
    else if (acc) exp_addr = nxt(exp_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    ifc.ready = 1'b0;
    ifc.jump  = 1'b0;
    ifc.jump_addr = 8'd0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_addr = 8'd0;
  endtask

  task automatic test_reset();
    ifc.ready = 1'b1;
    ifc.jump  = 1'b0;
    ifc.jump_addr = 8'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ifc.valid !== 1'b0 || ifc.address !== 8'd0 || ifc.instr !== 8'd0 || ifc.instr_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b addr=%h instr=%h iaddr=%h, required 0/00/00/00",
               ifc.valid, ifc.address, ifc.instr, ifc.instr_addr);
    end
    rst = 1'b0;
    exp_addr = 8'd0;
  endtask

  task automatic test_stream();
    tick(1'b1, 1'b0, 8'd0);
    checks++;
    if (ifc.valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_edge1_valid: got %b required 0", ifc.valid);
    end
    tick(1'b1, 1'b0, 8'd0);
    checks++;
    if (ifc.valid !== 1'b1 || ifc.instr !== 8'hA5 || ifc.instr_addr !== 8'h00) begin
      errors++;
      $display("FAIL stream_first: valid=%b instr=%h iaddr=%h required 1/a5/00",
               ifc.valid, ifc.instr, ifc.instr_addr);
    end
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 1'b0, 8'd0);
      checks++;
      if (!acc || got_a !== 8'(k) || got_i !== (8'(k) ^ 8'hA5)) begin
        errors++;
        $display("FAIL stream_word%0d: acc=%b iaddr=%h instr=%h required 1/%h/%h",
                 k, acc, got_a, got_i, 8'(k), 8'(k) ^ 8'hA5);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    apply_reset();
    repeat (10) tick(1'b0, 1'b0, 8'd0);
    checks++;
    if (dut.count_q !== 3'd4 || ifc.address !== 8'd4 || ifc.instr_addr !== 8'd0) begin
      errors++;
      $display("FAIL bp_hold: count=%0d addr=%h iaddr=%h required 4/04/00",
               dut.count_q, ifc.address, ifc.instr_addr);
    end
    n = 0;
    for (int c = 0; c < 20 && n < 6; c++) begin
      tick(1'b1, 1'b0, 8'd0);
      if (acc) begin
        checks++;
        if (got_a !== 8'(n) || got_i !== mem[8'(n)]) begin
          errors++;
          $display("FAIL bp_resume%0d: iaddr=%h instr=%h required %h/%h",
                   n, got_a, got_i, 8'(n), mem[8'(n)]);
        end
        n++;
      end
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL bp_timeout: accepted %0d words required 6", n);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] want [4];
    want[0] = 8'd126; want[1] = 8'd127; want[2] = 8'd0; want[3] = 8'd1;
    tick(1'b1, 1'b1, 8'd126);
    checks++;
    if (ifc.address !== 8'd126 || ifc.valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_jump: addr=%h valid=%b required 7e/0", ifc.address, ifc.valid);
    end
    tick(1'b1, 1'b0, 8'd0);
    checks++;
    if (ifc.valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_e1_valid: got %b required 0", ifc.valid);
    end
    tick(1'b1, 1'b0, 8'd0);
    checks++;
    if (ifc.valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_e2_valid: got %b required 1", ifc.valid);
    end
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0, 8'd0);
      checks++;
      if (!acc || got_a !== want[k] || got_i !== (want[k] ^ 8'hA5) || got_a !== exp_a) begin
        errors++;
        $display("FAIL wrap_word%0d: acc=%b iaddr=%h instr=%h required 1/%h/%h",
                 k, acc, got_a, got_i, want[k], want[k] ^ 8'hA5);
      end
    end
  endtask

  task automatic test_jump_full();
    repeat (8) tick(1'b0, 1'b0, 8'd0);
    tick(1'b0, 1'b1, 8'h40);
    checks++;
    if (ifc.valid !== 1'b0) begin
      errors++;
      $display("FAIL jf_flush: valid=%b required 0", ifc.valid);
    end
    tick(1'b0, 1'b0, 8'd0);
    checks++;
    if (ifc.valid !== 1'b0) begin
      errors++;
      $display("FAIL jf_e1_valid: got %b required 0", ifc.valid);
    end
    tick(1'b0, 1'b0, 8'd0);
    checks++;
    if (ifc.valid !== 1'b1 || ifc.instr_addr !== 8'h40 || ifc.instr !== 8'hE5) begin
      errors++;
      $display("FAIL jf_first: valid=%b iaddr=%h instr=%h required 1/40/e5",
               ifc.valid, ifc.instr_addr, ifc.instr);
    end
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b0, 8'd0);
      checks++;
      if (!acc || got_a !== exp_a || got_i !== mem[exp_a]) begin
        errors++;
        $display("FAIL jf_word%0d: acc=%b iaddr=%h instr=%h required 1/%h/%h",
                 k, acc, got_a, got_i, exp_a, mem[exp_a]);
      end
    end
  endtask

  task automatic test_jump_oor_held();
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b1, 8'd200);
      checks++;
      if (ifc.valid !== 1'b0 || ifc.address !== 8'd0) begin
        errors++;
        $display("FAIL oor_held%0d: valid=%b addr=%h required 0/00", k, ifc.valid, ifc.address);
      end
    end
    tick(1'b1, 1'b0, 8'd0);
    checks++;
    if (ifc.valid !== 1'b0) begin
      errors++;
      $display("FAIL oor_e1_valid: got %b required 0", ifc.valid);
    end
    tick(1'b1, 1'b0, 8'd0);
    checks++;
    if (ifc.valid !== 1'b1 || ifc.instr_addr !== 8'd0 || ifc.instr !== 8'hA5) begin
      errors++;
      $display("FAIL oor_first: valid=%b iaddr=%h instr=%h required 1/00/a5",
               ifc.valid, ifc.instr_addr, ifc.instr);
    end
  endtask

  task automatic test_async_reset();
    tick(1'b0, 1'b1, 8'h10);
    repeat (4) tick(1'b0, 1'b0, 8'd0);
    checks++;
    if (dut.count_q !== 3'd3 || ifc.instr_addr !== 8'h10) begin
      errors++;
      $display("FAIL ar_setup: count=%0d iaddr=%h required 3/10", dut.count_q, ifc.instr_addr);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ifc.valid !== 1'b0 || ifc.address !== 8'd0 || ifc.instr !== 8'd0 || ifc.instr_addr !== 8'd0) begin
      errors++;
      $display("FAIL ar_immediate: valid=%b addr=%h instr=%h iaddr=%h required 0/00/00/00",
               ifc.valid, ifc.address, ifc.instr, ifc.instr_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_addr = 8'd0;
    test_stream();
  endtask

  task automatic test_random();
    logic r, j;
    logic [7:0] ja;
    for (int c = 0; c < 400; c++) begin
      r  = ($urandom_range(0, 9) < 7);
      j  = ($urandom_range(0, 24) == 0);
      ja = 8'($urandom_range(0, 255));
      tick(r, j, ja);
      if (j) begin
        checks++;
        if (ifc.valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_flush: valid=%b required 0 at cycle %0d", ifc.valid, c);
        end
      end
      if (acc) begin
        checks++;
        if (got_a !== exp_a || got_i !== mem[exp_a]) begin
          errors++;
          $display("FAIL rand_word: cycle %0d iaddr=%h instr=%h required %h/%h",
                   c, got_a, got_i, exp_a, mem[exp_a]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    ifc.ready = 1'b0;
    ifc.jump = 1'b0;
    ifc.jump_addr = 8'd0;
    exp_addr = 8'd0;
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_jump_full();
    test_jump_oor_held();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch unit that drives the synchronous-read program ram's Address port and captures its Data one cycle later into a small prefetch FIFO. It presents instructions to the decoder through a valid/ready handshake. It supports a jump redirect that flushes buffered and in-flight fetches. It sits between the program ram and the processor's decode stage.

## Interface

- ADDR_W, 8: ram address width.
- DATA_W, 8: ram word width.
- DEPTH, 4: prefetch FIFO entries; power of two, at least 2.
- LAST_ADDR, 127: highest populated ram word; the fetch address wraps to 0 after it.

- Clock  in  1  single clock; the ram shares it.
- Reset  in  1  asynchronous, active-high reset.
- Address  out  ADDR_W  to ram; driven directly from the PC register.
- Data  in  DATA_W  from ram; holds mem[Address sampled at the previous edge].
- Jump  in  1  redirect request, sampled at posedge.
- JumpAddr  in  ADDR_W  redirect target.
- Instr  out  DATA_W  FIFO head word.
- InstrAddr  out  ADDR_W  address the head word was fetched from.
- Valid  out  1  FIFO non-empty.
- Ready  in  1  consumer accepts the head word.

## Operation

- **State**
  - PC: next address to fetch.
  - req_q: a valid request is in flight, so Data is meaningful this cycle.
  - addr_q: address of the in-flight request.
  - FIFO of {word, addr}, with count 0..DEPTH.
- **Issue**
  - Condition: at a posedge, issue = !Jump && (count + req_q < DEPTH). Use the pre-edge values and give no credit for a same-edge pop.
  - On issue: req_q <= 1, addr_q <= PC, PC <= (PC == LAST_ADDR) ? 0 : PC+1.
  - Otherwise: req_q <= 0 and PC holds. The ram still reads Address, but the result is ignored.
- **Push**: at a posedge, if req_q && !Jump, write {Data, addr_q} at the tail.
- **Pop**: at a posedge, if Valid && Ready && !Jump, advance the head.
  - Simultaneous push and pop leaves count unchanged.
  - A pop on an empty FIFO cannot occur, because Valid gates it.
  - Overflow cannot occur by the credit rule. The bench asserts count never exceeds DEPTH.
- **Jump** (priority over everything at that edge)
  - count <= 0 and req_q <= 0. Any in-flight Data is discarded and Ready is ignored.
  - PC <= JumpAddr if JumpAddr <= LAST_ADDR, else 0.
  - Jump held high for several cycles re-flushes each cycle. No fetch is issued while Jump = 1.
- **Outputs**
  - Valid = (count != 0).
  - Instr and InstrAddr come from the head entry and are combinational from registers.
  - When Valid = 0 they show stale storage and are don't-care.
- **Reset** (asynchronous, immediate, also mid-operation)
  - PC = 0, Address = 0, req_q = 0, addr_q = 0, count = 0, head and tail pointers = 0.
  - Valid = 0; all FIFO storage = 0, so Instr = 0 and InstrAddr = 0.
  - Data in flight at assertion is lost.

## Timing

- Ram contract: ram latches Address at edge k; Data is valid after edge k until edge k+1. The fetch unit samples it at edge k+1.
- After Reset deasserts:
  - edge 1 issues address 0;
  - edge 2 pushes word 0;
  - Valid = 1 after edge 2.
- Jump latency, with Jump sampled at edge E:
  - Address = target after E;
  - issue at E+1;
  - push at E+2;
  - Valid with InstrAddr = target after E+2.
- Throughput: with Ready held at 1, one word is delivered per cycle with no bubbles. Steady state is count ≤ 1 and req_q = 1.
- Backpressure: with Ready = 0, count reaches DEPTH and issue stops. Address then rests at the first unfetched address.
- Restart after backpressure: when Ready returns, at most one bubble may appear after the FIFO drains. Order and contents are preserved exactly.

## Test plan

- **Reset and stream**
  - Stimulus: ram image mem[i] = i ^ 8'hA5, Ready = 1.
  - Required: Valid first rises after the 2nd edge post-reset. (Instr, InstrAddr) = (A5,00), (A4,01), (A7,02)... with one word per cycle.
- **Backpressure**
  - Stimulus: Ready = 0 for 10 cycles after the stream starts.
  - Required: count stops at 4 holding addresses 0–3 and Address holds at 4. When Ready = 1, the output continues 0,1,2,3,4,5 with no loss or duplication.
- **Wrap**
  - Stimulus: Jump with JumpAddr = 126, Ready = 1.
  - Required: Valid 2 edges later, then InstrAddr = 126, 127, 0, 1 with words mem[126], mem[127], mem[0], mem[1].
- **Jump while full and in flight**
  - Stimulus: FIFO full, Ready = 0; pulse Jump with JumpAddr = 0x40.
  - Required: Valid = 0 after the jump edge, and no pre-jump word ever appears. First word is InstrAddr = 0x40, Instr = 0xE5, 2 edges later.
- **Out-of-range jump and held Jump**
  - Stimulus: JumpAddr = 200 with Jump held high for 3 cycles.
  - Required: Valid stays 0 throughout. After release, the first InstrAddr = 0.
- **Asynchronous reset mid-stream**
  - Stimulus: assert Reset between edges while count = 3.
  - Required: Valid = 0, Address = 0 and Instr = 0 immediately, without waiting for a clock edge. Restart then matches the reset-and-stream scenario.
